load_store_unit: RTL and testbench
==================================

# load_store_unit

Multicycle load/store unit between the ALU result and data memory. It takes an effective address (ALU output) plus store data (rs2) and the instruction's funct3, and runs byte-enabled word transactions on a simple req/ack memory bus. It returns the sign- or zero-extended load result, which the top level latches as `Data` for the ResultSrc mux. The control FSM issues one request per load/store and waits for the response pulse.

## Interface

- `MEM_SIZE`, default 1024: data memory size in bytes; accesses touching byte address ≥ MEM_SIZE fault.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request strobe from control FSM.
- `req_ready` out 1: high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: LB=000, LH=001, LW=010, LBU=100, LHU=101; stores SB=000, SH=001, SW=010.
- `req_addr` in 32 (`addr_t`): effective byte address.
- `req_wdata` in 32 (`data_t`): store data, rs2.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32 (`data_t`): extended load data; 0 for stores and faults.
- `resp_fault` out 1: valid with `resp_valid`.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 32 (always word-aligned), `mem_wdata` out 32, `mem_be` out 4: memory bus request.
- `mem_ack` in 1, `mem_rdata` in 32: memory completion and read word.

## Operation

- States: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - `req_valid` latches all request fields and goes to ACC0, or to RESP with fault.
  - Size is 1/2/4 bytes from funct3[1:0].
- Fault conditions:
  - funct3 ∉ {000,001,010,100,101} for loads.
  - funct3 ∉ {000,001,010} for stores.
  - addr + size − 1 ≥ MEM_SIZE.
  - Misalignment when `LSU_MISALIGN_TRAP_EN` is defined.
  - A faulting request issues no bus transaction.
- ACC0:
  - Drive `mem_addr` = addr & ~3.
  - `mem_be` = size mask << addr[1:0], truncated to 4 bits.
  - `mem_wdata` = wdata << 8·addr[1:0].
  - Hold all bus outputs stable until `mem_ack`.
  - On ack: if the access crosses a word boundary, capture rdata and go to ACC1; else go to RESP.
- ACC1:
  - `mem_addr` = (addr & ~3) + 4.
  - `mem_be` = remaining bytes in low lanes.
  - `mem_wdata` = wdata >> 8·(4 − addr[1:0]).
  - On ack, go to RESP.
- Load assembly:
  - Concatenate {ACC1 word, ACC0 word} and shift right by 8·addr[1:0].
  - Mask to size; sign-extend for LB/LH, zero-extend for LBU/LHU.
- RESP: `resp_valid` = 1 for one cycle, then IDLE.
- `mem_ack` while `mem_req` = 0 is ignored.

## Timing

- Reset values: all outputs 0 except `req_ready` = 1; state IDLE.
- Reset mid-transaction: `mem_req` drops immediately (async); the request is discarded with no response.
- Zero-wait aligned access: accept at cycle 0; `mem_req` in cycle 1 with `mem_ack`; `resp_valid` in cycle 2.
- Each wait cycle adds 1. A split access adds ≥ 1 bus cycle.
- Fault: accept at cycle 0, `resp_valid` in cycle 1.
- `req_ready` = 0 from the cycle after accept through RESP inclusive. The earliest next accept is the cycle after RESP.
- `resp_rdata` and `resp_fault` are registered and valid only while `resp_valid` = 1; otherwise 0.

## Configuration

- `LSU_MISALIGN_TRAP_EN` defined:
  - Any access with addr % size ≠ 0 faults.
  - ACC1 is unreachable and may be optimised out.
- Not defined:
  - Misaligned accesses are legal.
  - A word-crossing access is split into ACC0/ACC1 transactions.
  - Misaligned accesses within one word use a single transaction.

## Structure

- `types.svh` holds `data_t`, `addr_t`, and a new `lsu_funct3_t` enum (LB, LH, LW, LBU, LHU).
- The state enum stays local to the module.
- One sub-module, `lsu_load_align`: combinational; takes two words, offset and funct3; returns the extended result.
- Stores use inline shift logic.

## Test plan

- LW at 0x10, `mem_rdata` 0xDEADBEEF, ack in first cycle → `resp_valid` at cycle 2, rdata 0xDEADBEEF, fault 0.
- LB at 0x13, word 0x80112233, 2 wait states → rdata 0xFFFFFF80; LBU at the same address → 0x00000080.
- SH at 0x06, wdata 0x0000ABCD → one transaction: addr 0x04, be 1100, wdata 0xABCD0000.
- LW at 0x0E, macro off, words 0x44332211 / 0x88776655 → two transactions at 0x0C and 0x10, rdata 0x66554433. With the macro defined → fault at cycle 1, no `mem_req`.
- LW at 0x3FE with MEM_SIZE = 1024, or load funct3 = 011 → fault, rdata 0, no bus activity.
- Reset asserted while `mem_req` = 1 awaiting ack → `mem_req` = 0 immediately. No `resp_valid` after reset release. The next request completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: data/address words, load funct3 codes
// and access-size helpers.
package load_store_unit_pkg;

  typedef logic [31:0] data_t;
  typedef logic [31:0] addr_t;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } lsu_funct3_t;

  function automatic logic [2:0] acc_size(input logic [1:0] sz);
    case (sz)
      2'b00:   acc_size = 3'd1;
      2'b01:   acc_size = 3'd2;
      default: acc_size = 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Load data alignment: picks the addressed bytes out of a two-word window
// and sign- or zero-extends them according to funct3.
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  data_t       i_word0,
  input  data_t       i_word1,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output data_t       o_data
);

  data_t w_sh;

  assign w_sh = 32'({i_word1, i_word0} >> {i_off, 3'b000});

  always_comb begin
    o_data = w_sh;
    unique case (i_funct3)
      LB:      o_data = {{24{w_sh[7]}}, w_sh[7:0]};
      LH:      o_data = {{16{w_sh[15]}}, w_sh[15:0]};
      LBU:     o_data = {24'b0, w_sh[7:0]};
      LHU:     o_data = {16'b0, w_sh[15:0]};
      default: o_data = w_sh;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store unit on a req/ack word bus, splitting word-crossing
// accesses in two. Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [2:0] req_funct3,
  input  addr_t      req_addr,
  input  data_t      req_wdata,
  output logic       resp_valid,
  output data_t      resp_rdata,
  output logic       resp_fault,
  output logic       mem_req,
  output logic       mem_we,
  output addr_t      mem_addr,
  output data_t      mem_wdata,
  output logic [3:0] mem_be,
  input  logic       mem_ack,
  input  data_t      mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t r_state, w_next;

  logic       r_we;
  logic [2:0] r_f3;
  addr_t      r_addr;
  data_t      r_wdata;
  data_t      r_word0;
  data_t      r_rdata;
  logic       r_fault;

  logic [2:0]  w_size;
  logic [32:0] w_end;
  logic        w_bad_f3;
  logic        w_oob;
  logic        w_mis;
  logic        w_fault;

  assign w_size = acc_size(req_funct3[1:0]);
  assign w_end  = {1'b0, req_addr} + 33'(w_size) - 33'd1;
  assign w_oob  = w_end >= 33'(MEM_SIZE);
  assign w_bad_f3 = req_we
    ? (req_funct3[2] | (&req_funct3[1:0]))
    : ((&req_funct3[1:0]) | (req_funct3[2] & req_funct3[1]));
`ifdef LSU_MISALIGN_TRAP_EN
  assign w_mis = |(req_addr[1:0] & (w_size[1:0] - 2'd1));
`else
  assign w_mis = 1'b0;
`endif
  assign w_fault = w_bad_f3 | w_oob | w_mis;

  logic [1:0]  w_off;
  logic [7:0]  w_mask8;
  logic        w_cross;
  logic [63:0] w_wide;
  addr_t       w_base;
  data_t       w_lw0;
  data_t       w_lw1;
  data_t       w_ld;

  // Byte lanes past lane 3 belong to the following word
  assign w_off   = r_addr[1:0];
  assign w_mask8 = {4'b0, size_mask(r_f3[1:0])} << w_off;
  assign w_cross = |w_mask8[7:4];
  assign w_wide  = {32'b0, r_wdata} << {w_off, 3'b000};
  assign w_base  = {r_addr[31:2], 2'b00};

  assign w_lw0 = (r_state == ACC1) ? r_word0 : mem_rdata;
  assign w_lw1 = (r_state == ACC1) ? mem_rdata : '0;

  lsu_load_align u_align (
    .i_word0  (w_lw0),
    .i_word1  (w_lw1),
    .i_off    (w_off),
    .i_funct3 (r_f3),
    .o_data   (w_ld)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;
    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = w_fault ? RESP : ACC0;
      end
      ACC0: begin
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_addr  = w_base;
        mem_wdata = w_wide[31:0];
        mem_be    = w_mask8[3:0];
        if (mem_ack) w_next = w_cross ? ACC1 : RESP;
      end
      ACC1: begin
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_addr  = w_base + 32'd4;
        mem_wdata = w_wide[63:32];
        mem_be    = w_mask8[7:4];
        if (mem_ack) w_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        w_next     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_word0 <= '0;
      r_rdata <= '0;
      r_fault <= 1'b0;
    end else begin
      if (r_state == IDLE && req_valid) begin
        r_we    <= req_we;
        r_f3    <= req_funct3;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_fault <= w_fault;
        r_rdata <= '0;
      end
      if (r_state == ACC0 && mem_ack && w_cross)
        r_word0 <= mem_rdata;
      if (mem_ack && ((r_state == ACC0 && !w_cross) || r_state == ACC1))
        r_rdata <= r_we ? '0 : w_ld;
    end
  end

  assign resp_rdata = (r_state == RESP) ? r_rdata : '0;
  assign resp_fault = (r_state == RESP) & r_fault;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level memory reference model,
// randomised memory wait states and requests, plus directed corner cases.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int MEM = 1024;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid, req_ready, req_we;
  logic [2:0] req_funct3;
  addr_t      req_addr;
  data_t      req_wdata;
  logic       resp_valid, resp_fault;
  data_t      resp_rdata;
  logic       mem_req, mem_we, mem_ack;
  addr_t      mem_addr;
  data_t      mem_wdata, mem_rdata;
  logic [3:0] mem_be;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_SIZE(MEM)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          ntx;
    int          acc;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  ref_mem [MEM];
  logic [31:0] bus_mem [MEM/4];
  logic [31:0] log_addr[$];
  logic [3:0]  log_be[$];
  logic [31:0] log_wd[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int cfg_wait = -1;
  int wait_sum = 0;
  logic [31:0] last_rdata;
  logic        last_fault;
  int          last_lat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic we, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int sz;
    longint last;
    logic [31:0] v;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    e.fault = we ? !(f3 inside {3'd0, 3'd1, 3'd2})
                 : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    last = longint'(a) + longint'(sz) - 1;
    if (last >= longint'(MEM)) e.fault = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((a % sz) != 0) e.fault = 1'b1;
`endif
    e.rdata = '0;
    e.ntx = 0;
    e.acc = 0;
    if (!e.fault) begin
      e.ntx = ((a % 4) + sz > 4) ? 2 : 1;
      if (we) begin
        for (int i = 0; i < sz; i++) ref_mem[a + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < sz; i++) v |= 32'(ref_mem[a + i]) << (8 * i);
        if (!f3[2] && sz < 4 && v[8*sz-1]) v |= ~((32'd1 << (8 * sz)) - 1);
        e.rdata = v;
      end
    end
    return e;
  endfunction

  task automatic poke(input int a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) ref_mem[a + i] = w[8*i +: 8];
    bus_mem[a / 4] = w;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int t;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("ready_timeout", 32'(req_ready), 32'd1);
    if (req_ready) begin
      e = model(we, f3, a, wd);
      e.acc = cyc;
      log_addr.delete(); log_be.delete(); log_wd.delete();
      wait_sum = 0;
      q.push_back(e);
      @(posedge clk);
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  // Memory responder: random or fixed wait states, random ack noise when idle
  initial begin
    int wl;
    logic in_tx;
    logic [72:0] snap;
    wl = 0; in_tx = 1'b0; snap = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!mem_req) begin
        in_tx = 1'b0;
        mem_ack = 1'($urandom);
        mem_rdata = $urandom;
      end else begin
        if (!in_tx) begin
          in_tx = 1'b1;
          wl = (cfg_wait < 0) ? int'($urandom_range(0, 2)) : cfg_wait;
          wait_sum += wl;
          snap = {mem_we, mem_be, mem_addr, mem_wdata};
          log_addr.push_back(mem_addr);
          log_be.push_back(mem_be);
          log_wd.push_back(mem_wdata);
          check("addr_align", 32'(mem_addr[1:0]), 32'd0);
          check("addr_range", 32'(mem_addr < MEM), 32'd1);
        end else begin
          check("bus_stable", 32'(snap == {mem_we, mem_be, mem_addr, mem_wdata}),
                32'd1);
        end
        if (wl == 0) begin
          mem_ack = 1'b1;
          mem_rdata = bus_mem[(mem_addr / 4) % (MEM / 4)];
          if (mem_we)
            for (int k = 0; k < 4; k++)
              if (mem_be[k])
                bus_mem[(mem_addr / 4) % (MEM / 4)][8*k +: 8] = mem_wdata[8*k +: 8];
          in_tx = 1'b0;
        end else begin
          wl--;
          mem_rdata = $urandom;
        end
      end
    end
  end

  // Monitor: pops one expectation per completion pulse
  initial begin
    exp_t e;
    int lat;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (q.size() == 0) begin
          check("unexpected_resp", 32'(resp_valid), 32'd0);
        end else begin
          e = q.pop_front();
          lat = cyc - e.acc;
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_fault", 32'(resp_fault), 32'(e.fault));
          check("bus_tx", 32'(log_addr.size()), 32'(e.ntx));
          check("latency", 32'(lat), e.fault ? 32'd1 : 32'(e.ntx + wait_sum + 1));
          check("ready_low", 32'(req_ready), 32'd0);
          last_rdata = resp_rdata;
          last_fault = resp_fault;
          last_lat = lat;
        end
      end else begin
        check("idle_rdata", resp_rdata, 32'd0);
        check("idle_fault", 32'(resp_fault), 32'd0);
      end
    end
  end

  initial begin
    logic [2:0] lf3 [5];
    logic we;
    logic [2:0] f3;
    logic [31:0] a;
    int t, r, mism;
    lf3[0] = 3'b000; lf3[1] = 3'b001; lf3[2] = 3'b010;
    lf3[3] = 3'b100; lf3[4] = 3'b101;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    last_rdata = '0; last_fault = 1'b0; last_lat = 0;
    for (int i = 0; i < MEM / 4; i++) poke(4 * i, $urandom);

    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b1;

    poke(32'h10, 32'hDEADBEEF);
    cfg_wait = 0;
    issue(1'b0, 3'b010, 32'h10, '0); drain();
    check("lw_data", last_rdata, 32'hDEADBEEF);
    check("lw_lat", 32'(last_lat), 32'd2);

    poke(32'h10, 32'h80112233);
    cfg_wait = 2;
    issue(1'b0, 3'b000, 32'h13, '0); drain();
    check("lb_data", last_rdata, 32'hFFFFFF80);
    check("lb_lat", 32'(last_lat), 32'd4);
    issue(1'b0, 3'b100, 32'h13, '0); drain();
    check("lbu_data", last_rdata, 32'h00000080);

    cfg_wait = -1;
    issue(1'b1, 3'b001, 32'h06, 32'h0000ABCD); drain();
    check("sh_ntx", 32'(log_addr.size()), 32'd1);
    if (log_addr.size() > 0) begin
      check("sh_addr", log_addr[0], 32'h04);
      check("sh_be", 32'(log_be[0]), 32'hC);
      check("sh_wdata", log_wd[0], 32'hABCD0000);
    end

    poke(32'h0C, 32'h44332211);
    poke(32'h10, 32'h88776655);
    issue(1'b0, 3'b010, 32'h0E, '0); drain();
`ifdef LSU_MISALIGN_TRAP_EN
    check("split_fault", 32'(last_fault), 32'd1);
    check("split_lat", 32'(last_lat), 32'd1);
`else
    check("split_data", last_rdata, 32'h66554433);
    check("split_ntx", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() == 2) begin
      check("split_a0", log_addr[0], 32'h0C);
      check("split_a1", log_addr[1], 32'h10);
      check("split_be0", 32'(log_be[0]), 32'hC);
      check("split_be1", 32'(log_be[1]), 32'h3);
    end
`endif

    issue(1'b0, 3'b010, 32'h3FE, '0); drain();
    check("oob_fault", 32'(last_fault), 32'd1);
    check("oob_rdata", last_rdata, 32'd0);
    issue(1'b0, 3'b011, 32'h20, '0); drain();
    check("f3_fault", 32'(last_fault), 32'd1);
    issue(1'b0, 3'b010, 32'h3FC, '0); drain();
    check("top_word_ok", 32'(last_fault), 32'd0);

    cfg_wait = 6;
    issue(1'b0, 3'b010, 32'h40, '0);
    t = 0;
    while (!mem_req && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("rst_tx_started", 32'(mem_req), 32'd1);
    #2 reset = 1'b0;
    #1 check("rst_drop_req", 32'(mem_req), 32'd0);
    check("rst_drop_ready", 32'(req_ready), 32'd1);
    q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    cfg_wait = -1;
    issue(1'b0, 3'b010, 32'h40, '0); drain();
    check("post_rst_ok", 32'(last_fault), 32'd0);

    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom);
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
      else if (we) f3 = 3'($urandom_range(0, 2));
      else f3 = lf3[$urandom_range(0, 4)];
      r = $urandom_range(0, 19);
      if (r == 0) a = $urandom;
      else if (r < 3) a = 32'(MEM - 4 + $urandom_range(0, 7));
      else a = 32'($urandom_range(0, MEM - 1));
      issue(we, f3, a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    mism = 0;
    for (int i = 0; i < MEM; i++)
      if (bus_mem[i / 4][8*(i % 4) +: 8] !== ref_mem[i]) mism++;
    check("mem_image", 32'(mism), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
